// File: rtl/slc3_isdu.sv
// SLC-3 instruction sequence/decode unit: Moore FSM driving every datapath
// load, bus gate, mux select and memory strobe for fetch/decode/execute.
module slc3_isdu #(
  parameter int MEM_WAIT          = 3,
  parameter bit PAUSE_AFTER_FETCH = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
  output logic       GatePC, GateMDR, GateALU, GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE, Mem_WE
);

  typedef enum logic [4:0] {
    HALTED, S18, RD_F, S35, PIR1, PIR2, S32,
    S1, S5, S9, S22, S12, S4, S21, S20,
    S6, RD_L, S27, S7, S23, WR, PI1, PI2
  } state_t;

  localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

  state_t     state, state_n;
  logic [2:0] cnt;
  logic       in_mem, mem_done;

  assign in_mem   = (state == RD_F) || (state == RD_L) || (state == WR);
  assign mem_done = (cnt == LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= HALTED;
      cnt   <= '0;
    end else begin
      state <= state_n;
      // counter restarts on every entry into a memory access
      cnt   <= (in_mem && state_n == state) ? cnt + 3'd1 : 3'd0;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      HALTED: if (Run) state_n = S18;
      S18:    state_n = RD_F;
      RD_F:   if (mem_done) state_n = S35;
      S35:    state_n = PAUSE_AFTER_FETCH ? PIR1 : S32;
      PIR1:   if (Continue) state_n = PIR2;
      PIR2:   if (!Continue) state_n = S32;
      S32: begin
        unique case (Opcode)
          4'b0001: state_n = S1;
          4'b0101: state_n = S5;
          4'b1001: state_n = S9;
          4'b0000: state_n = BEN ? S22 : S18;
          4'b1100: state_n = S12;
          4'b0100: state_n = S4;
          4'b0110: state_n = S6;
          4'b0111: state_n = S7;
          4'b1101: state_n = PI1;
          default: state_n = S18;
        endcase
      end
      S4:     state_n = IR_11 ? S21 : S20;
      S6:     state_n = RD_L;
      RD_L:   if (mem_done) state_n = S27;
      S7:     state_n = S23;
      S23:    state_n = WR;
      WR:     if (mem_done) state_n = S18;
      PI1:    if (Continue) state_n = PI2;
      PI2:    if (!Continue) state_n = S18;
      default: state_n = S18;
    endcase
  end

  always_comb begin
    {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = '0;
    {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
    PCMUX = 2'b00; ADDR2MUX = 2'b00; ALUK = 2'b00;
    {DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE} = '0;
    unique case (state)
      S18: begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; end
      RD_F, RD_L: begin Mem_OE = 1'b1; LD_MDR = mem_done; end
      S35: begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S32: LD_BEN = 1'b1;
      S1, S5, S9: begin
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        SR1MUX = 1'b1; SR2MUX = IR_5;
        ALUK = (state == S5) ? 2'b01 : (state == S9) ? 2'b10 : 2'b00;
      end
      S22: begin LD_PC = 1'b1; PCMUX = 2'b10; ADDR2MUX = 2'b10; end
      S12, S20: begin LD_PC = 1'b1; PCMUX = 2'b10; SR1MUX = 1'b1; ADDR1MUX = 1'b1; end
      S4:  begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
      S21: begin LD_PC = 1'b1; PCMUX = 2'b10; ADDR2MUX = 2'b11; end
      S6, S7: begin
        GateMARMUX = 1'b1; LD_MAR = 1'b1; SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01;
      end
      S27: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S23: begin ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1; end
      WR:  Mem_WE = 1'b1;
      PI1, PI2: LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_slc3_isdu.sv
// Directed table-driven bench for slc3_isdu (MEM_WAIT=3, PAUSE_AFTER_FETCH=1):
// each row drives inputs for one edge and checks the Moore outputs after it.
module tb_slc3_isdu;

  logic Clk = 1'b0, Reset, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;

  slc3_isdu dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  always #5 Clk = ~Clk;

  // bit map of the flattened output word
  localparam logic [23:0] MAR = 24'h1 << 23, MDR = 24'h1 << 22, LIR = 24'h1 << 21,
    LBEN = 24'h1 << 20, LCC = 24'h1 << 19, LREG = 24'h1 << 18, LPC = 24'h1 << 17,
    LLED = 24'h1 << 16, GPC = 24'h1 << 15, GMDR = 24'h1 << 14, GALU = 24'h1 << 13,
    GMM = 24'h1 << 12, PC_ADR = 24'h2 << 10, DR7 = 24'h1 << 9, SR1 = 24'h1 << 8,
    SR2 = 24'h1 << 7, A1 = 24'h1 << 6, A2_6 = 24'h1 << 4, A2_9 = 24'h2 << 4,
    A2_11 = 24'h3 << 4, PASS = 24'h3 << 2, OE = 24'h2, WE = 24'h1;

  localparam logic [23:0] HALT = 24'h0, ST18 = GPC | MAR | LPC, RD = OE, RDL = OE | MDR,
    ST35 = GMDR | LIR, PAUSE = 24'h0, ST32 = LBEN, ADDI = GALU | LREG | LCC | SR1 | SR2,
    ST22 = LPC | PC_ADR | A2_9, ST7 = GMM | MAR | SR1 | A1 | A2_6, ST23 = PASS | GALU | MDR,
    ST27 = GMDR | LREG | LCC, ST4 = GPC | DR7 | LREG, ST21 = LPC | PC_ADR | A2_11;

  typedef struct {
    logic rst, run, cont, ir5, ir11, ben;
    logic [3:0] op;
    logic [23:0] exp;
    string name;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0, nfail = 0;

  function automatic logic [23:0] outs();
    return {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
            GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
            ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};
  endfunction

  task automatic add(input logic rst, run, cont, input logic [3:0] op,
                     input logic ir5, ir11, ben, input logic [23:0] exp, input string name);
    vec_t v;
    v.rst = rst; v.run = run; v.cont = cont; v.op = op;
    v.ir5 = ir5; v.ir11 = ir11; v.ben = ben; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  // fetch from S18 through the IR pause handshake into S32
  task automatic add_fetch(input logic [3:0] op, input logic ir5, ir11, ben);
    add(0, 0, 0, op, ir5, ir11, ben, RD,    "fetch_oe1");
    add(0, 0, 0, op, ir5, ir11, ben, RD,    "fetch_oe2");
    add(0, 0, 0, op, ir5, ir11, ben, RDL,   "fetch_oe3_mdr");
    add(0, 0, 0, op, ir5, ir11, ben, ST35,  "s35");
    add(0, 0, 0, op, ir5, ir11, ben, PAUSE, "pauseir1");
    add(0, 0, 1, op, ir5, ir11, ben, PAUSE, "pauseir2");
    add(0, 0, 0, op, ir5, ir11, ben, ST32,  "s32");
  endtask

  task automatic step(input logic rst, run, cont, input logic [3:0] op,
                      input logic ir5, ir11, ben, input logic [23:0] exp, input string name);
    Reset = rst; Run = run; Continue = cont; Opcode = op;
    IR_5 = ir5; IR_11 = ir11; BEN = ben;
    @(posedge Clk); #1;
    nvec++;
    if (outs() !== exp) begin
      nfail++;
      $display("FAIL %s: outputs=%06h expected=%06h", name, outs(), exp);
    end
  endtask

  initial begin
    Reset = 1; Run = 0; Continue = 0; Opcode = 0; IR_5 = 0; IR_11 = 0; BEN = 0;

    add(1, 0, 0, 4'h0, 0, 0, 0, HALT, "reset1");
    add(1, 0, 0, 4'h0, 0, 0, 0, HALT, "reset2");
    for (int i = 0; i < 10; i++) add(0, 0, 0, 4'h0, 0, 0, 0, HALT, "halted_idle");
    add(0, 1, 0, 4'h0, 0, 0, 0, ST18, "run_s18");
    // first fetch holds in PauseIR1 while Continue stays low
    add_fetch(4'h1, 1, 0, 0);
    vecs.delete(vecs.size() - 1);
    vecs.delete(vecs.size() - 1);
    add(0, 0, 0, 4'h1, 1, 0, 0, PAUSE, "pauseir1_hold");
    add(0, 0, 0, 4'h1, 1, 0, 0, PAUSE, "pauseir1_hold");
    for (int i = 0; i < 4; i++) add(0, 0, 1, 4'h1, 1, 0, 0, PAUSE, "pauseir_cont");
    add(0, 0, 0, 4'h1, 1, 0, 0, ST32, "add_s32");
    add(0, 0, 0, 4'h1, 1, 0, 0, ADDI, "add_exec");
    add(0, 0, 0, 4'h1, 1, 0, 0, ST18, "add_to_s18");
    // BR taken
    add_fetch(4'h0, 0, 0, 1);
    add(0, 0, 0, 4'h0, 0, 0, 1, ST22, "br_s22");
    add(0, 0, 0, 4'h0, 0, 0, 1, ST18, "br_to_s18");
    // BR not taken
    add_fetch(4'h0, 0, 0, 0);
    add(0, 0, 0, 4'h0, 0, 0, 0, ST18, "br_nt_s18");
    // STR
    add_fetch(4'h7, 0, 0, 0);
    add(0, 0, 0, 4'h7, 0, 0, 0, ST7,  "str_s7");
    add(0, 0, 0, 4'h7, 0, 0, 0, ST23, "str_s23");
    for (int i = 0; i < 3; i++) add(0, 0, 0, 4'h7, 0, 0, 0, WE, "str_we");
    add(0, 0, 0, 4'h7, 0, 0, 0, ST18, "str_to_s18");
    // LDR
    add_fetch(4'h6, 0, 0, 0);
    add(0, 0, 0, 4'h6, 0, 0, 0, ST7,  "ldr_s6");
    add(0, 0, 0, 4'h6, 0, 0, 0, RD,   "ldr_oe1");
    add(0, 0, 0, 4'h6, 0, 0, 0, RD,   "ldr_oe2");
    add(0, 0, 0, 4'h6, 0, 0, 0, RDL,  "ldr_oe3_mdr");
    add(0, 0, 0, 4'h6, 0, 0, 0, ST27, "ldr_s27");
    add(0, 0, 0, 4'h6, 0, 0, 0, ST18, "ldr_to_s18");
    // JSR with offset
    add_fetch(4'h4, 0, 1, 0);
    add(0, 0, 0, 4'h4, 0, 1, 0, ST4,  "jsr_s4");
    add(0, 0, 0, 4'h4, 0, 1, 0, ST21, "jsr_s21");
    add(0, 0, 0, 4'h4, 0, 1, 0, ST18, "jsr_to_s18");
    // PAUSE instruction
    add_fetch(4'hD, 0, 0, 0);
    add(0, 0, 0, 4'hD, 0, 0, 0, LLED, "pausei1");
    add(0, 0, 0, 4'hD, 0, 0, 0, LLED, "pausei1_hold");
    add(0, 0, 1, 4'hD, 0, 0, 0, LLED, "pausei2");
    add(0, 0, 0, 4'hD, 0, 0, 0, ST18, "pausei_to_s18");
    // Run low outside Halted is ignored
    add(0, 0, 0, 4'h0, 0, 0, 0, RD, "run_low_ignored");

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].run, vecs[i].cont, vecs[i].op,
           vecs[i].ir5, vecs[i].ir11, vecs[i].ben, vecs[i].exp, vecs[i].name);

    // reset during the second read strobe of a fetch aborts the access
    step(1, 0, 0, 4'h0, 0, 0, 0, HALT, "abort_reset");
    step(0, 1, 0, 4'h0, 0, 0, 0, ST18, "abort_s18");
    step(0, 0, 0, 4'h0, 0, 0, 0, RD,   "abort_oe1");
    step(0, 0, 0, 4'h0, 0, 0, 0, RD,   "abort_oe2");
    step(1, 0, 0, 4'h0, 0, 0, 0, HALT, "abort_halted");
    step(0, 0, 0, 4'h0, 0, 0, 0, HALT, "abort_no_strobe");
    step(1, 1, 0, 4'h0, 0, 0, 0, HALT, "reset_beats_run");
    step(0, 1, 0, 4'h0, 0, 0, 0, ST18, "restart_s18");
    step(0, 0, 0, 4'h0, 0, 0, 0, RD,   "restart_oe1");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/slc3_isdu.md
Name: slc3_isdu

Overview:
Instruction sequence and decode unit for the SLC-3 processor. A Moore FSM that sequences fetch, decode and execute for the lab instruction subset, and drives every load, gate, mux-select and memory strobe of the SLC-3 datapath. It sits between the top-level Run/Continue pushbuttons and the datapath/memory inside the SLC-3 top. It also handles the PAUSE-on-fetch and PAUSE-instruction handshakes.

Parameters:
MEM_WAIT, 3, number of cycles Mem_OE or Mem_WE is held per memory access (range 1..7).
PAUSE_AFTER_FETCH, 1, when 1, stop after every IR load and wait for a Continue handshake.

Ports:
Clk  in  1  system clock, rising-edge.
Reset  in  1  synchronous, active-high; forces the Halted state.
Run  in  1  level, start execution from Halted.
Continue  in  1  level, used for the pause handshake.
Opcode  in  4  IR[15:12].
IR_5  in  1  IR[5], immediate select for ADD/AND.
IR_11  in  1  IR[11], JSR vs JSRR.
BEN  in  1  branch-enable register output.
LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register load enables.
GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high per cycle.
PCMUX  out  2  00 PC+1, 01 bus, 10 address adder.
DRMUX  out  1  0 IR[11:9], 1 R7.
SR1MUX  out  1  0 IR[11:9], 1 IR[8:6].
SR2MUX  out  1  0 register, 1 sext imm5.
ADDR1MUX  out  1  0 PC, 1 SR1.
ADDR2MUX  out  2  00 zero, 01 off6, 10 off9, 11 off11.
ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS A.
Mem_OE, Mem_WE  out  1 each  active-high memory read/write strobes.

Behaviour:
- Clock and reset: one clock (Clk). Reset is synchronous and active-high. Next state is Halted. All outputs are 0 in Halted. A Reset asserted mid-access aborts the access with no further strobe cycle.
- Outputs are purely a function of state (Moore). Any output not listed for a state is 0. No output depends combinationally on Run or Continue.
- Memory read sequence (MEM_RD): MEM_WAIT states with Mem_OE=1. LD_MDR=1 only in the last state. A 3-bit wait counter is cleared on entry and counts to MEM_WAIT-1.
- Memory write sequence (MEM_WR): MEM_WAIT states with Mem_WE=1 and nothing else.
- Halted: go to S18 when Run=1.
- S18: GatePC, LD_MAR, LD_PC, PCMUX=00. Next is MEM_RD(fetch).
- S35: GateMDR, LD_IR. Next is PauseIR1 if PAUSE_AFTER_FETCH=1, otherwise S32.
- PauseIR1: hold while Continue=0, advance on Continue=1.
- PauseIR2: hold while Continue=1, advance to S32 on Continue=0. This gives exactly one instruction per press.
- S32: LD_BEN. Decode on Opcode:
  - 0001 ADD, 0101 AND, 1001 NOT: one state each with GateALU, LD_REG, LD_CC, SR1MUX=1, SR2MUX=IR_5, DRMUX=0. Then S18.
  - 0000 BR: go to S22 if BEN=1, else S18. S22: PCMUX=10, ADDR1MUX=0, ADDR2MUX=10, LD_PC. Then S18.
  - 1100 JMP: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC. Then S18.
  - 0100 JSR:
    - S4: GatePC, DRMUX=1, LD_REG.
    - S21 when IR_11=1: PCMUX=10, ADDR2MUX=11, ADDR1MUX=0.
    - S20 when IR_11=0: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10.
    - S21 and S20 both assert LD_PC. Then S18.
  - 0110 LDR:
    - S6: GateMARMUX, LD_MAR, SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01.
    - Then MEM_RD.
    - S27: GateMDR, LD_REG, LD_CC, DRMUX=0. Then S18.
  - 0111 STR:
    - S7: as S6.
    - S23: SR1MUX=0, ALUK=11, GateALU, LD_MDR.
    - Then MEM_WR, then S18.
  - 1101 PAUSE: PauseI1/PauseI2 with the same handshake as PauseIR. LD_LED=1 in both states. Then S18.
  - Any other opcode: S18 (treated as NOP).
- Run=0 is ignored outside Halted. Only Reset returns the FSM to Halted.
- Simultaneous Reset and Run: Reset wins.

Test Plan:
1. Reset high for 2 cycles, then low with Run=0 -> FSM stays Halted and every output is 0 for 10 cycles.
2. Reset, then Run=1 at cycle 2 (PAUSE_AFTER_FETCH=1, MEM_WAIT=3) -> S18 at cycle 3 with LD_PC=1. Mem_OE=1 on cycles 4-6, LD_MDR on cycle 6, LD_IR on cycle 7. Then the FSM holds in PauseIR1.
3. Continue pulses 1 for 4 cycles then 0, with IR=0x1263 (ADD, IR_5=1) -> exactly one cycle of GateALU/LD_REG/LD_CC with SR2MUX=1. Next state S18.
4. Opcode 0000, BEN=1 -> S22 asserts LD_PC with PCMUX=10 and ADDR2MUX=10. With BEN=0 -> no LD_PC after S32; next state S18.
5. Opcode 0111 -> S7 (LD_MAR), S23 (LD_MDR, ALUK=11), Mem_WE=1 for exactly 3 cycles, Mem_OE never high.
6. Reset asserted during the second Mem_OE cycle of a fetch -> Mem_OE is 0 on the next edge and the FSM is in Halted. Run=1 then restarts at S18.
